uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART0 byte transmitter between two framed byte-stream requesters:
//    req0 = telemetry/status reporter, req1 = command-reply path.
//  Round-robin arbitration at frame granularity. A grant is held until the requester's
//  last byte is accepted, so frames never interleave on the wire.
//  A per-grant idle watchdog reclaims the transmitter from a requester that stalls mid-frame.
//  Sits between the requesters and the uart transmitter inside system.
// PARAMETERS
//  TIMEOUT_CYC  50000  cycles a granted requester may hold req_valid low before its grant is revoked
//  TO_W         16     width of the watchdog counter; must satisfy 2**TO_W > TIMEOUT_CYC
// PORTS
//  clk          in   1  system clock; single clock domain
//  rst          in   1  asynchronous reset, active-low
//  req0_valid   in   1  requester 0 presents a byte
//  req0_data    in   8  requester 0 byte
//  req0_last    in   1  byte is the final byte of the frame
//  req0_ready   out  1  byte accepted this cycle (valid&ready = transfer)
//  req1_valid   in   1  requester 1 presents a byte
//  req1_data    in   8  requester 1 byte
//  req1_last    in   1  byte is the final byte of the frame
//  req1_ready   out  1  byte accepted this cycle
//  tx_busy      in   1  uart transmitter shifting; rises at most 1 cycle after tx_wr
//  tx_wr        out  1  single-cycle write strobe to the uart transmitter
//  tx_data      out  8  byte to the uart transmitter; valid when tx_wr=1
//  grant        out  2  one-hot current owner; 00 when idle
//  timeout      out  2  1-cycle pulse; bit i set when requester i's grant is revoked by the watchdog
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, grant=00, tx_wr=0, tx_data=00, readys=0, timeout=00,
//   prio pointer=0 (req0 favoured), watchdog=0.
//  FSM states: IDLE, SEND, GUARD.
//  IDLE: if any reqN_valid, grant the valid requester.
//   - Both valid: grant the one the prio pointer favours.
//   - Grant registers next cycle; go to SEND.
//   - No byte is transferred in the grant cycle.
//  SEND: owner i.
//   - If req_i_valid & !tx_busy: assert req_i_ready and tx_wr for exactly 1 cycle
//     (combinational ready, registered tx_data/tx_wr acceptable if ready aligns with the capture edge).
//   - Latency: valid while SEND & !tx_busy -> tx_wr in the same or next cycle; fixed per implementation.
//   - After a transfer: if req_i_last, release (grant=00, prio pointer -> other requester, go IDLE);
//     else go GUARD.
//   - If req_i_valid=0: watchdog increments. On reaching TIMEOUT_CYC: pulse timeout[i],
//     release, prio pointer -> other requester, go IDLE.
//   - Watchdog clears on every transfer and on every new grant. It does not count while
//     valid=1 & tx_busy=1 (back-pressure is not a stall).
//  GUARD: exactly 1 cycle; covers tx_busy rise latency; always returns to SEND.
//  Non-owner ready is always 0; non-owner valid is ignored and may be held indefinitely.
//  At most one tx_wr per GUARD+SEND pair; tx_wr never asserts while tx_busy=1.
//  Simultaneous release and new request: the released requester's pending valid in the
//   next IDLE loses to the other requester if both are valid.
//  Single-byte frame (valid & last on the first byte) is legal; release follows the same cycle rules.
//  Reset mid-frame: everything returns to reset values immediately; a partially sent frame is
//   truncated, and requesters must restart their frame.
//  Counter arithmetic is unsigned TO_W bits and saturates at TIMEOUT_CYC; it never wraps.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/SEND/GUARD), REQ_TELEM=0 / REQ_CMD=1 index constants,
//   and the default TIMEOUT_CYC.
//  One natural sub-module: rr_pick2, the combinational 2-way round-robin picker
//   (valid[1:0], prio -> onehot). Watchdog counter and FSM live in the top.
// TESTING
//  1. Reset: hold rst=0 with both valids high -> grant=00, tx_wr=0, readys=0, timeout=00 throughout.
//  2. req0 frame 0x41,0x42,0x43(last), bench uart busy 10 cycles per byte -> three tx_wr in order,
//     none while tx_busy=1, grant returns to 00 after 0x43.
//  3. Both request simultaneously after reset -> req0 full frame first, then req1 frame,
//     then req0 again; no byte interleaving.
//  4. req1 granted, sends 0x10, drops valid; TIMEOUT_CYC=20 -> timeout=10 pulse 20 cycles later,
//     grant released, waiting req0 granted next.
//  5. Single-byte frames alternating from both requesters for 100 frames -> strict alternation,
//     byte count per requester exactly 50.
//  6. Assert rst=0 mid-frame after byte 2 of 5 -> outputs reset asynchronously;
//     after release the next frame starts cleanly with prio on req0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART0 transmitter arbiter: FSM encoding, requester
// indices and default watchdog sizing.
package uart_tx_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SEND  = 2'd1;
   localparam logic [1:0] ST_GUARD = 2'd2;

   localparam int REQ_TELEM = 0;
   localparam int REQ_CMD   = 1;

   localparam int TIMEOUT_CYC_DEFAULT = 50000;
   localparam int TO_W_DEFAULT        = 16;

   // One requester's byte-stream beat, packed so the owner can be selected by index.
   typedef struct packed {
      logic       valid;
      logic [7:0] data;
      logic       last;
   } req_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: one-hot choice among valid requesters,
// ties broken by the priority pointer (0 favours requester 0).
module rr_pick2 (
   input  logic [1:0] valid_i,
   input  logic       prio_i,
   output logic [1:0] pick_o
);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      pick_o = valid_i;
      if (&valid_i) begin
         pick_o         = 2'b00;
         pick_o[prio_i] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART byte transmitter between
// the telemetry and command-reply requesters, with a per-grant stall watchdog.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
   parameter int TO_W        = TO_W_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid_i,
   input  logic [7:0] req0_data_i,
   input  logic       req0_last_i,
   output logic       req0_ready_o,
   input  logic       req1_valid_i,
   input  logic [7:0] req1_data_i,
   input  logic       req1_last_i,
   output logic       req1_ready_o,
   input  logic       tx_busy_i,
   output logic       tx_wr_o,
   output logic [7:0] tx_data_o,
   output logic [1:0] grant_o,
   output logic [1:0] timeout_o
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [1:0]      state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic            prio_q, prio_d;
   logic [TO_W-1:0] wd_q, wd_d;
   logic            tx_wr_q, tx_wr_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [1:0]      timeout_q, timeout_d;

   req_t [1:0] req;
   req_t       own;
   logic       owner;
   logic [1:0] pick;
   logic       xfer;

   assign req[REQ_TELEM] = {req0_valid_i, req0_data_i, req0_last_i};
   assign req[REQ_CMD]   = {req1_valid_i, req1_data_i, req1_last_i};

   assign owner = grant_q[REQ_CMD];
   assign own   = req[owner];

   // Ready is combinational; the accepted byte is registered onto tx_data/tx_wr one cycle later.
   assign xfer = (state_q == ST_SEND) && own.valid && !tx_busy_i;

   rr_pick2 u_pick (
      .valid_i({req1_valid_i, req0_valid_i}),
      .prio_i (prio_q),
      .pick_o (pick)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      prio_d    = prio_q;
      wd_d      = wd_q;
      tx_wr_d   = 1'b0;
      tx_data_d = tx_data_q;
      timeout_d = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (|pick) begin
               grant_d = pick;
               wd_d    = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               tx_wr_d   = 1'b1;
               tx_data_d = own.data;
               wd_d      = '0;
               if (own.last) begin
                  grant_d = 2'b00;
                  prio_d  = ~owner;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GUARD;
               end
            end else if (!own.valid) begin
               // Compare with >= so the counter can never run past the limit and wrap.
               if (wd_q >= TO_LAST) begin
                  timeout_d[owner] = 1'b1;
                  grant_d          = 2'b00;
                  prio_d           = ~owner;
                  wd_d             = '0;
                  state_d          = ST_IDLE;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
         end
         ST_GUARD: state_d = ST_SEND;
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= 2'b00;
         prio_q    <= 1'b0;
         wd_q      <= '0;
         tx_wr_q   <= 1'b0;
         tx_data_q <= 8'h00;
         timeout_q <= 2'b00;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         prio_q    <= prio_d;
         wd_q      <= wd_d;
         tx_wr_q   <= tx_wr_d;
         tx_data_q <= tx_data_d;
         timeout_q <= timeout_d;
      end
   end

   assign req0_ready_o = xfer && grant_q[REQ_TELEM];
   assign req1_ready_o = xfer && grant_q[REQ_CMD];
   assign tx_wr_o      = tx_wr_q;
   assign tx_data_o    = tx_data_q;
   assign grant_o      = grant_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester expected byte queues filled at
// stimulus time, a monitor that attributes each tx_wr to its owner, and a UART busy model.
module tb_uart_tx_arbiter;

   localparam int TO_CYC = 20;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] vld;
   logic [7:0] dat [2];
   logic [1:0] lst;
   logic [1:0] rdy;
   logic       tx_busy;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic [1:0] grant;
   logic [1:0] timeout;

   uart_tx_arbiter #(.TIMEOUT_CYC(TO_CYC), .TO_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid_i(vld[0]),
      .req0_data_i (dat[0]),
      .req0_last_i (lst[0]),
      .req0_ready_o(rdy[0]),
      .req1_valid_i(vld[1]),
      .req1_data_i (dat[1]),
      .req1_last_i (lst[1]),
      .req1_ready_o(rdy[1]),
      .tx_busy_i   (tx_busy),
      .tx_wr_o     (tx_wr),
      .tx_data_o   (tx_data),
      .grant_o     (grant),
      .timeout_o   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus and scoreboard state
   beat_t drv_q [2][$];
   beat_t exp_q [2][$];
   int    frame_owners[$];
   int    tx_count [2];
   int    tx_cyc   [2];
   int    cur_owner;
   int    cyc;
   int    busy_len;
   bit    bubbles;
   bit    to_expect;
   bit    to_seen;
   logic [1:0] to_val;
   logic [1:0] to_grant;
   int    to_cyc;

   // UART model: busy for busy_len cycles starting the cycle after each write strobe
   logic [5:0] busy_cnt;
   assign tx_busy = (busy_cnt != 6'd0);
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)               busy_cnt <= 6'd0;
      else if (tx_wr)           busy_cnt <= 6'(busy_len);
      else if (busy_cnt != 6'd0) busy_cnt <= busy_cnt - 6'd1;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic enq(input int r, input logic [7:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      drv_q[r].push_back(b);
      exp_q[r].push_back(b);
   endtask

   task automatic send_frame(input int r, input int len);
      for (int i = 0; i < len; i++) enq(r, 8'($urandom), (i == len - 1));
   endtask

   task automatic flush();
      for (int r = 0; r < 2; r++) begin
         drv_q[r].delete();
         exp_q[r].delete();
      end
      cur_owner = -1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      flush();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while ((drv_q[0].size() != 0 || drv_q[1].size() != 0 || exp_q[0].size() != 0 ||
              exp_q[1].size() != 0 || tx_busy || tx_wr) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check("drain_within_budget", (n < max_cyc), 1);
      repeat (2) @(negedge clk);
   endtask

   // Requester drivers: present the queue head, pop on handshake, optional gap before each next byte
   for (genvar g = 0; g < 2; g++) begin : g_drv
      initial begin
         logic acc;
         int   gap;
         vld[g] = 1'b0;
         dat[g] = 8'h00;
         lst[g] = 1'b0;
         gap    = 0;
         forever begin
            @(negedge clk);
            acc = vld[g] && rdy[g];
            @(posedge clk);
            #1;
            if (acc && drv_q[g].size() != 0) begin
               void'(drv_q[g].pop_front());
               gap = bubbles ? int'($urandom_range(0, 3)) : 0;
            end
            if (gap > 0) begin
               gap--;
               vld[g] = 1'b0;
            end else if (drv_q[g].size() != 0) begin
               vld[g] = 1'b1;
               dat[g] = drv_q[g][0].data;
               lst[g] = drv_q[g][0].last;
            end else begin
               vld[g] = 1'b0;
            end
         end
      end
   end

   // Monitor: attribute each strobe to the owner of the previous cycle and compare against its queue
   initial begin
      logic [1:0] gprev;
      int         o;
      beat_t      e;
      gprev = 2'b00;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rdy[0]) check("ready0_only_when_owner", grant, 2'b01);
            if (rdy[1]) check("ready1_only_when_owner", grant, 2'b10);
            if (tx_wr) begin
               check("tx_wr_while_busy", tx_busy, 1'b0);
               o = (gprev == 2'b01) ? 0 : (gprev == 2'b10) ? 1 : -1;
               check("tx_wr_has_owner", (o >= 0), 1);
               if (o >= 0) begin
                  if (cur_owner >= 0) check("no_interleave", o, cur_owner);
                  check("byte_expected", (exp_q[o].size() != 0), 1);
                  if (exp_q[o].size() != 0) begin
                     e = exp_q[o].pop_front();
                     check("tx_data", tx_data, e.data);
                     if (e.last) begin
                        frame_owners.push_back(o);
                        cur_owner = -1;
                     end else begin
                        cur_owner = o;
                     end
                  end
                  tx_count[o]++;
                  tx_cyc[o] = cyc;
               end
            end
            if (timeout != 2'b00) begin
               check("timeout_expected", to_expect, 1'b1);
               to_seen   = 1'b1;
               to_val    = timeout;
               to_grant  = grant;
               to_cyc    = cyc;
               cur_owner = -1;
            end
         end
         gprev = grant;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      int base0, base1, breaks, n, delta;
      cur_owner = -1;
      cyc       = 0;
      tx_count  = '{0, 0};
      tx_cyc    = '{0, 0};
      busy_len  = 10;
      bubbles   = 1'b0;
      to_expect = 1'b0;
      to_seen   = 1'b0;
      to_val    = 2'b00;
      to_grant  = 2'b00;
      to_cyc    = 0;
      rst_n     = 1'b0;

      // Reset held with both requesters valid, then contention: req0, req1, req0
      send_frame(0, 3);
      send_frame(1, 2);
      send_frame(0, 2);
      repeat (6) begin
         @(negedge clk);
         check("rst_grant", grant, 2'b00);
         check("rst_tx_wr", tx_wr, 1'b0);
         check("rst_readys", rdy, 2'b00);
         check("rst_timeout", timeout, 2'b00);
         check("rst_tx_data", tx_data, 8'h00);
      end
      rst_n = 1'b1;
      wait_drain(3000);
      check("contention_frames", frame_owners.size(), 3);
      if (frame_owners.size() == 3) begin
         check("contention_first", frame_owners[0], 0);
         check("contention_second", frame_owners[1], 1);
         check("contention_third", frame_owners[2], 0);
      end

      // Three-byte telemetry frame with 10-cycle UART occupancy
      frame_owners.delete();
      base0 = tx_count[0];
      enq(0, 8'h41, 1'b0);
      enq(0, 8'h42, 1'b0);
      enq(0, 8'h43, 1'b1);
      wait_drain(1000);
      check("frame3_bytes", tx_count[0] - base0, 3);
      check("frame3_owner", (frame_owners.size() == 1) ? frame_owners[0] : -1, 0);
      check("frame3_grant_released", grant, 2'b00);

      // 100 single-byte frames with both requesters saturated: strict alternation
      do_reset();
      frame_owners.delete();
      busy_len = int'($urandom_range(2, 12));
      base0 = tx_count[0];
      base1 = tx_count[1];
      for (int i = 0; i < 50; i++) begin
         enq(0, 8'($urandom), 1'b1);
         enq(1, 8'($urandom), 1'b1);
      end
      wait_drain(5000);
      breaks = 0;
      for (int i = 1; i < frame_owners.size(); i++)
         if (frame_owners[i] == frame_owners[i-1]) breaks++;
      check("alt_frames", frame_owners.size(), 100);
      check("alt_first_owner", (frame_owners.size() != 0) ? frame_owners[0] : -1, 0);
      check("alt_breaks", breaks, 0);
      check("alt_count_req0", tx_count[0] - base0, 50);
      check("alt_count_req1", tx_count[1] - base1, 50);

      // Randomized mixed traffic with gaps and back-pressure longer than the watchdog limit
      frame_owners.delete();
      bubbles = 1'b1;
      for (int k = 0; k < 40; k++) begin
         busy_len = int'($urandom_range(1, 30));
         send_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
         repeat (int'($urandom_range(0, 30))) @(negedge clk);
      end
      wait_drain(20000);
      bubbles = 1'b0;
      check("random_frames", frame_owners.size(), 40);

      // Watchdog: req1 stalls after one byte while req0 waits
      frame_owners.delete();
      busy_len  = 10;
      to_expect = 1'b1;
      to_seen   = 1'b0;
      enq(1, 8'h10, 1'b0);
      n = 0;
      while (grant != 2'b10 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("stall_grant_req1", grant, 2'b10);
      send_frame(0, 2);
      n = 0;
      while (!to_seen && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("timeout_seen", to_seen, 1'b1);
      check("timeout_bit", to_val, 2'b10);
      check("timeout_grant_released", to_grant, 2'b00);
      delta = to_cyc - tx_cyc[1];
      check("timeout_delay_window", (delta >= TO_CYC && delta <= TO_CYC + 2), 1);
      @(negedge clk);
      check("timeout_single_pulse", timeout, 2'b00);
      to_expect = 1'b0;
      wait_drain(1000);
      check("after_timeout_owner", (frame_owners.size() == 1) ? frame_owners[0] : -1, 0);

      // Reset after byte 2 of 5; the next contention must favour req0 again
      frame_owners.delete();
      base0 = tx_count[0];
      for (int i = 0; i < 5; i++) enq(0, 8'($urandom), (i == 4));
      n = 0;
      while (tx_count[0] < base0 + 2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("midframe_two_bytes", tx_count[0] - base0, 2);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_grant", grant, 2'b00);
      check("async_rst_tx_wr", tx_wr, 1'b0);
      check("async_rst_readys", rdy, 2'b00);
      check("async_rst_tx_data", tx_data, 8'h00);
      check("async_rst_timeout", timeout, 2'b00);
      flush();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      send_frame(1, 2);
      send_frame(0, 2);
      wait_drain(1000);
      check("post_rst_frames", frame_owners.size(), 2);
      check("post_rst_first", (frame_owners.size() != 0) ? frame_owners[0] : -1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
